// File: rtl/reg_file.sv
// reg_file: 32 x WIDTH register file, one write port, two combinational read ports.
// The register at index ZERO_REG is never enabled, so it holds its reset value (0) forever.
module reg_file #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  localparam int unsigned NumRegs = 32;

  // Mask that strips the hard-wired zero register out of the write enables.
  localparam logic [NumRegs-1:0] ZeroMask = NumRegs'(1) << ZERO_REG;

  logic [NumRegs-1:0]            wr_dec;
  logic [NumRegs-1:0]            reg_en;
  logic [NumRegs-1:0][WIDTH-1:0] reg_q;

  // 5:32 one-hot write decoder, gated by wr_en.
  always_comb begin
    wr_dec          = '0;
    if (wr_en) begin
      wr_dec[wr_addr] = 1'b1;
    end
  end

  // Per-register load enables; writes aimed at the zero register are dropped here.
  always_comb begin
    reg_en = wr_dec & ~ZeroMask;
  end

  for (genvar r = 0; r < NumRegs; r++) begin : g_reg
    // Storage element: async clear, load on its decoded enable, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        reg_q[r] <= '0;
      end else if (reg_en[r]) begin
        reg_q[r] <= wr_data;
      end
    end
  end

  // Each output bit is a 32:1 mux over the same bit of every register.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NumRegs-1:0] col;

    for (genvar r = 0; r < NumRegs; r++) begin : g_col
      assign col[r] = reg_q[r][b];
    end

    assign rd_data1[b] = col[rd_addr1];
    assign rd_data2[b] = col[rd_addr2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an
// array model that is updated from the architectural write rule.
module tb_reg_file;

  localparam int unsigned W = 64;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [4:0]   rd_addr1;
  logic [4:0]   rd_addr2;
  logic [W-1:0] rd_data1;
  logic [W-1:0] rd_data2;

  reg_file #(
    .WIDTH   (W),
    .ZERO_REG(31)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [W-1:0] model [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: reset clears everything, a write lands unless aimed at register 31.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] <= '0;
    end else if (wr_en && wr_addr != 5'd31) begin
      model[wr_addr] <= wr_data;
    end
  end

  // Continuous compare on the falling edge, when inputs and state are settled.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_rd1", rd_data1, model[rd_addr1]);
      chk("cmp_rd2", rd_data2, model[rd_addr2]);
    end
  end

  // Apply inputs, let one rising edge sample them, return just after that edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr1 = a1;
    rd_addr2 = a2;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] exp;

    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reads while held in reset, with a write attempt present.
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wr_data = 64'h1234;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 32; i += 4) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      chk("in_reset_rd1", rd_data1, '0);
      chk("in_reset_rd2", rd_data2, '0);
    end
    wr_en  = 1'b0;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Every index reads 0 after reset.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
      chk("post_reset_rd1", rd_data1, '0);
      chk("post_reset_rd2", rd_data2, '0);
    end

    // Fill all indices, then read back on both ports.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 5'(i), 64'h100 + 64'(i), 5'(i), 5'(i));
    end
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 5'd0, '0, 5'(i), 5'(i));
      exp = (i == 31) ? 64'h0 : 64'h100 + 64'(i);
      chk("fill_rd1", rd_data1, exp);
      chk("fill_rd2", rd_data2, exp);
    end

    // All-ones write to the zero register is discarded.
    cyc(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd0);
    chk("zero_reg_rd", rd_data1, 64'h0);
    chk("zero_reg_r0", rd_data2, 64'h100);
    for (int i = 0; i < 31; i++) begin
      cyc(1'b0, 5'd0, '0, 5'(i), 5'(30 - i));
      chk("zero_keep_rd1", rd_data1, 64'h100 + 64'(i));
      chk("zero_keep_rd2", rd_data2, 64'h100 + 64'(30 - i));
    end

    // Same-cycle write and read of register 5: old value before the edge, new after.
    cyc(1'b1, 5'd5, 64'hA, 5'd5, 5'd5);
    chk("r5_a", rd_data1, 64'hA);
    wr_en    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 64'hB;
    rd_addr1 = 5'd5;
    #1;
    chk("no_bypass", rd_data1, 64'hA);
    @(posedge clk);
    #2;
    chk("after_edge", rd_data1, 64'hB);

    // Disabled write over three edges leaves register 7 alone.
    for (int k = 0; k < 3; k++) cyc(1'b0, 5'd7, 64'hDEAD_BEEF, 5'd7, 5'd7);
    chk("wr_en_low_r7", rd_data1, 64'h107);

    // Asynchronous reset between edges, write ignored during reset, write after release.
    cyc(1'b0, 5'd0, '0, 5'd3, 5'd9);
    chk("pre_rst_r3", rd_data1, 64'h103);
    chk("pre_rst_r9", rd_data2, 64'h109);
    reset = 1'b0;
    #1;
    chk("async_rst_r3", rd_data1, 64'h0);
    chk("async_rst_r9", rd_data2, 64'h0);
    cyc(1'b1, 5'd3, 64'h55, 5'd3, 5'd9);
    chk("rst_wr_ignored", rd_data1, 64'h0);
    reset = 1'b1;
    cyc(1'b1, 5'd3, 64'h1, 5'd3, 5'd9);
    chk("post_rst_wr_r3", rd_data1, 64'h1);
    chk("post_rst_r9", rd_data2, 64'h0);

    // Randomized traffic with occasional reset pulses; the compare process checks each cycle.
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 59) != 0);
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
          {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    reset = 1'b1;
    cyc(1'b0, 5'd0, '0, 5'd0, 5'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
